bf_relax_engine: RTL and testbench
==================================

// Module: bf_relax_engine
// PURPOSE
// Parametrised Bellman-Ford single-source shortest-path engine: initialises per-vertex distance/predecessor
// tables, streams the edge list from an external edge RAM, relaxes for up to V-1 passes with early exit,
// exposes results on a registered query port. Replaces the hard-coded 8-bit/128-bit controller+datapath
// pair; sits between the graph loader (owns edge RAM) and the path trace-back/output stage.
// PARAMETERS
// VERT_W   8    vertex index width; tables hold 2**VERT_W entries
// DIST_W   16   signed distance/weight width; INF = 2**(DIST_W-1)-1
// EDGE_AW  10   edge RAM address width; max 2**EDGE_AW edges
// PORTS
// clock       in   1          single clock, all logic posedge
// reset       in   1          asynchronous, active-high; clears FSM, flags, outputs
// start       in   1          1-cycle pulse; sampled only in IDLE
// vertex_num  in   VERT_W+1   vertex count V (0..2**VERT_W), latched on start
// edge_num    in   EDGE_AW+1  edge count E, latched on start
// source_num  in   VERT_W     source vertex, latched on start
// edge_addr   out  EDGE_AW    edge RAM read address
// edge_rd     out  1          edge RAM read strobe; data valid exactly 1 cycle later
// edge_src    in   VERT_W     edge source (valid cycle after edge_rd)
// edge_dst    in   VERT_W     edge destination
// edge_wt     in   DIST_W     signed edge weight
// busy        out  1          high from start accept until done
// done        out  1          1-cycle pulse on completion (also on error)
// err         out  1          latched: source_num>=V; cleared on next accepted start
// passes      out  VERT_W+1   relaxation passes executed in last run
// neg_cycle   out  1          latched negative-cycle flag (see CONFIGURATION)
// q_addr      in   VERT_W     query vertex
// q_dist      out  DIST_W     dist[q_addr], registered, 1-cycle latency
// q_pred      out  VERT_W     pred[q_addr], registered, 1-cycle latency
// BEHAVIOUR
// - Reset: state IDLE; busy,done,err,neg_cycle,edge_rd=0; passes,edge_addr,q_dist,q_pred=0. Tables not cleared.
// - IDLE -start-> INIT. V==0: done pulse next cycle, passes=0. source_num>=V: err=1, done, no table writes.
// - INIT: one vertex/cycle, dist=INF, pred=own index; source gets dist=0. V cycles. Then E==0 or V==1 -> DONE.
// - FETCH: edge_rd=1, edge_addr=e. RELAX (next cycle): cand=dist[src]+wt computed in DIST_W+1 bits,
//   saturated to [-(2**(DIST_W-1)), INF-1]; if dist[src]!=INF and cand<dist[dst]: dist[dst]=cand,
//   pred[dst]=src, set changed. 2 cycles/edge; dist write lands before next edge read (no hazard).
// - PASS_END after edge E-1: passes++; if !changed or passes==V-1 -> DONE (or CHECK); else clear changed, e=0, FETCH.
// - Self-loop src==dst: relaxes only if wt<0 (treated as normal edge). Edge indices >=V: edge skipped, no write.
// - start while busy ignored. Reset mid-run: abort to IDLE immediately, tables hold partial contents.
// - DONE: done=1 one cycle, busy=0, return IDLE. q_* readable any time; reads during run return live values.
// CONFIGURATION
// BF_NEG_CYCLE_DETECT_EN defined: if final pass ended with changed=1 at passes==V-1, run CHECK pass
//   (same FETCH/RELAX timing, no writes); any relaxable edge sets neg_cycle=1. passes excludes CHECK.
// Undefined: no CHECK state; neg_cycle tied 0; run ends after at most V-1 passes.
// STRUCTURE
// bf_pkg: state enum (IDLE,INIT,FETCH,RELAX,PASS_END,CHECK_FETCH,CHECK_RELAX,DONE), INF/NEG_MIN
//   localparam functions of DIST_W, saturate_add function.
// Sub-module bf_relax_alu (combinational): inputs dist_src,dist_dst,wt -> cand, do_update.
// Tables are plain register arrays inside bf_relax_engine (synth may map to distributed RAM).
// TESTING
// 1. V=4,src=0,edges 0->1(4),0->2(1),2->1(2),1->3(1): dist={0,3,1,4}, pred={0,2,0,1}, passes=2, done 1 pulse.
// 2. V=5 chain edges listed reverse order (3->4..0->1, wt 1): passes=4, dist[4]=4; forward order: passes=2.
// 3. V=3,src=5: err=1, done next cycle after start, no edge_rd asserted; next valid start clears err.
// 4. V=3, 0->1(1),1->2(-3),2->1(1) with EN: neg_cycle=1, passes=2; without EN: neg_cycle=0, passes=2.
// 5. DIST_W=8, 0->1(100),1->2(100): dist[2]=126 (saturated INF-1); unreachable vertex reads 127.
// 6. Reset asserted mid-RELAX: busy=0,done=0 next edge; restart with same graph gives test-1 results.

Source files
------------

// File: rtl/bf_relax_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_relax_engine_pkg
// Description : Shared types and helpers for the Bellman-Ford relax engine:
//               FSM state encoding, INF / NEG_MIN as functions of the
//               distance width, and the saturating candidate adder.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package bf_relax_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_INIT        = 3'd1,
    S_FETCH       = 3'd2,
    S_RELAX       = 3'd3,
    S_PASS_END    = 3'd4,
    S_CHECK_FETCH = 3'd5,
    S_CHECK_RELAX = 3'd6,
    S_DONE        = 3'd7
  } state_t;

  // Largest positive distance doubles as "unreachable".
  function automatic int inf_of(input int dist_w);
    return (1 << (dist_w - 1)) - 1;
  endfunction

  // Most negative representable distance.
  function automatic int neg_min_of(input int dist_w);
    return -(1 << (dist_w - 1));
  endfunction

  // dist + wt, clamped to [NEG_MIN, INF-1] so a finite path never turns into INF.
  function automatic int saturate_add(input int a, input int b, input int dist_w);
    longint s;
    s = longint'(a) + longint'(b);
    if (s > longint'(inf_of(dist_w) - 1)) return inf_of(dist_w) - 1;
    if (s < longint'(neg_min_of(dist_w))) return neg_min_of(dist_w);
    return int'(s);
  endfunction

endpackage : bf_relax_engine_pkg
`default_nettype wire

// File: rtl/bf_relax_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : bf_relax_engine_if
// Description : Control, edge-RAM and query bus of the relax engine. Names are
//               from the engine's point of view (i_ into it, o_ out of it).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface bf_relax_engine_if #(
  parameter int VERT_W  = 8,
  parameter int DIST_W  = 16,
  parameter int EDGE_AW = 10
);
  logic                     i_start;
  logic [VERT_W:0]          i_vertex_num;
  logic [EDGE_AW:0]         i_edge_num;
  logic [VERT_W-1:0]        i_source_num;
  logic [EDGE_AW-1:0]       o_edge_addr;
  logic                     o_edge_rd;
  logic [VERT_W-1:0]        i_edge_src;
  logic [VERT_W-1:0]        i_edge_dst;
  logic signed [DIST_W-1:0] i_edge_wt;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;
  logic [VERT_W:0]          o_passes;
  logic                     o_neg_cycle;
  logic [VERT_W-1:0]        i_q_addr;
  logic signed [DIST_W-1:0] o_q_dist;
  logic [VERT_W-1:0]        o_q_pred;

  modport master (
    output i_start, i_vertex_num, i_edge_num, i_source_num,
    output i_edge_src, i_edge_dst, i_edge_wt, i_q_addr,
    input  o_edge_addr, o_edge_rd, o_busy, o_done, o_err,
    input  o_passes, o_neg_cycle, o_q_dist, o_q_pred
  );

  modport slave (
    input  i_start, i_vertex_num, i_edge_num, i_source_num,
    input  i_edge_src, i_edge_dst, i_edge_wt, i_q_addr,
    output o_edge_addr, o_edge_rd, o_busy, o_done, o_err,
    output o_passes, o_neg_cycle, o_q_dist, o_q_pred
  );
endinterface : bf_relax_engine_if
`default_nettype wire

// File: rtl/bf_relax_engine_alu.sv
`default_nettype none
// ============================================================================
// Module      : bf_relax_engine_alu
// Description : Combinational relax step: cand = sat(dist_src + wt) and the
//               decision whether it improves dist_dst. A source still at INF
//               never relaxes anything.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bf_relax_engine_alu
  import bf_relax_engine_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  wire logic signed [DIST_W-1:0] i_dist_src,
  input  wire logic signed [DIST_W-1:0] i_dist_dst,
  input  wire logic signed [DIST_W-1:0] i_wt,
  output logic signed [DIST_W-1:0]      o_cand,
  output logic                          o_do_update
);
  localparam logic signed [DIST_W-1:0] c_inf = DIST_W'(inf_of(DIST_W));

  logic signed [DIST_W-1:0] w_cand;

  // Saturating add, then signed compare against the current destination.
  always_comb begin
    w_cand      = DIST_W'(saturate_add(int'(i_dist_src), int'(i_wt), DIST_W));
    o_cand      = w_cand;
    o_do_update = (i_dist_src != c_inf) && (w_cand < i_dist_dst);
  end
endmodule : bf_relax_engine_alu
`default_nettype wire

// File: rtl/bf_relax_engine.sv
`default_nettype none
// ============================================================================
// Module      : bf_relax_engine
// Description : Bellman-Ford single-source shortest-path engine. Initialises
//               dist/pred tables, streams the edge list (2 cycles per edge),
//               relaxes for up to V-1 passes with early exit, and serves a
//               registered query port.
//               Optional macro BF_NEG_CYCLE_DETECT_EN adds a read-only CHECK
//               pass that flags negative cycles.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bf_relax_engine
  import bf_relax_engine_pkg::*;
#(
  parameter int VERT_W  = 8,
  parameter int DIST_W  = 16,
  parameter int EDGE_AW = 10
) (
  input wire logic           clk,
  input wire logic           rst,
  bf_relax_engine_if.slave   bus
);
  localparam logic signed [DIST_W-1:0] c_inf = DIST_W'(inf_of(DIST_W));

  state_t                   r_state;
  state_t                   w_next;
  logic [VERT_W:0]          r_vnum;
  logic [EDGE_AW:0]         r_enum;
  logic [VERT_W-1:0]        r_srcv;
  logic [VERT_W:0]          r_idx;
  logic [EDGE_AW-1:0]       r_e;
  logic [VERT_W:0]          r_passes;
  logic                     r_changed;
  logic                     r_err;
  logic signed [DIST_W-1:0] r_q_dist;
  logic [VERT_W-1:0]        r_q_pred;

  logic signed [DIST_W-1:0] r_dist [2**VERT_W];
  logic [VERT_W-1:0]        r_pred [2**VERT_W];

  logic                     w_v_zero;
  logic                     w_src_bad;
  logic                     w_init_last;
  logic                     w_edge_last;
  logic [VERT_W:0]          w_passes_inc;
  logic                     w_pass_limit;
  logic                     w_edge_ok;
  logic signed [DIST_W-1:0] w_cand;
  logic                     w_do_update;
  logic                     w_relax_wr;

  assign w_v_zero     = (bus.i_vertex_num == '0);
  assign w_src_bad    = ({1'b0, bus.i_source_num} >= bus.i_vertex_num);
  assign w_init_last  = (r_idx == r_vnum - 1'b1);
  assign w_edge_last  = ({1'b0, r_e} == r_enum - 1'b1);
  assign w_passes_inc = r_passes + 1'b1;
  assign w_pass_limit = (w_passes_inc == r_vnum - 1'b1);
  // Edges naming a vertex outside 0..V-1 are skipped without touching the tables.
  assign w_edge_ok    = ({1'b0, bus.i_edge_src} < r_vnum) && ({1'b0, bus.i_edge_dst} < r_vnum);
  assign w_relax_wr   = (r_state == S_RELAX) && w_edge_ok && w_do_update;

  bf_relax_engine_alu #(.DIST_W(DIST_W)) u_alu (
    .i_dist_src  (r_dist[bus.i_edge_src]),
    .i_dist_dst  (r_dist[bus.i_edge_dst]),
    .i_wt        (bus.i_edge_wt),
    .o_cand      (w_cand),
    .o_do_update (w_do_update)
  );

  // State register; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = (w_v_zero || w_src_bad) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        if (w_init_last) w_next = ((r_enum == '0) || (r_vnum == 1)) ? S_DONE : S_FETCH;
      end
      S_FETCH:  w_next = S_RELAX;
      S_RELAX:  w_next = w_edge_last ? S_PASS_END : S_FETCH;
      S_PASS_END: begin
        if (!r_changed)        w_next = S_DONE;
`ifdef BF_NEG_CYCLE_DETECT_EN
        else if (w_pass_limit) w_next = S_CHECK_FETCH;
`else
        else if (w_pass_limit) w_next = S_DONE;
`endif
        else                   w_next = S_FETCH;
      end
      S_CHECK_FETCH: w_next = S_CHECK_RELAX;
      S_CHECK_RELAX: w_next = w_edge_last ? S_DONE : S_CHECK_FETCH;
      S_DONE:        w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state; edge address comes from the edge counter.
  always_comb begin
    bus.o_edge_rd   = (r_state == S_FETCH) || (r_state == S_CHECK_FETCH);
    bus.o_edge_addr = r_e;
    bus.o_done      = (r_state == S_DONE);
    bus.o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  end

  // Run parameters, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vnum    <= '0;
      r_enum    <= '0;
      r_srcv    <= '0;
      r_idx     <= '0;
      r_e       <= '0;
      r_passes  <= '0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_vnum    <= bus.i_vertex_num;
            r_enum    <= bus.i_edge_num;
            r_srcv    <= bus.i_source_num;
            r_err     <= w_src_bad && !w_v_zero;
            r_idx     <= '0;
            r_e       <= '0;
            r_passes  <= '0;
            r_changed <= 1'b0;
          end
        end
        S_INIT:  r_idx <= r_idx + 1'b1;
        S_RELAX: begin
          if (w_relax_wr) r_changed <= 1'b1;
          r_e <= w_edge_last ? '0 : r_e + 1'b1;
        end
        S_PASS_END: begin
          r_passes  <= w_passes_inc;
          r_changed <= 1'b0;
        end
        S_CHECK_RELAX: r_e <= w_edge_last ? '0 : r_e + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef BF_NEG_CYCLE_DETECT_EN
  logic r_neg;

  // Any edge still relaxable during the check pass proves a negative cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_neg <= 1'b0;
    else if ((r_state == S_IDLE) && bus.i_start) r_neg <= 1'b0;
    else if ((r_state == S_CHECK_RELAX) && w_edge_ok && w_do_update) r_neg <= 1'b1;
  end
  assign bus.o_neg_cycle = r_neg;
`else
  assign bus.o_neg_cycle = 1'b0;
`endif

  // Distance/predecessor tables; deliberately not reset so partial results survive.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_dist[r_idx[VERT_W-1:0]] <= (r_idx[VERT_W-1:0] == r_srcv) ? '0 : c_inf;
      r_pred[r_idx[VERT_W-1:0]] <= r_idx[VERT_W-1:0];
    end else if (w_relax_wr) begin
      r_dist[bus.i_edge_dst] <= w_cand;
      r_pred[bus.i_edge_dst] <= bus.i_edge_src;
    end
  end

  // Registered query port, one cycle of latency, live during a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_dist <= '0;
      r_q_pred <= '0;
    end else begin
      r_q_dist <= r_dist[bus.i_q_addr];
      r_q_pred <= r_pred[bus.i_q_addr];
    end
  end

  assign bus.o_q_dist = r_q_dist;
  assign bus.o_q_pred = r_q_pred;
  assign bus.o_err    = r_err;
  assign bus.o_passes = r_passes;

endmodule : bf_relax_engine
`default_nettype wire

// File: tb/tb_bf_relax_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf_relax_engine
// Description : Directed bench for bf_relax_engine: a 16-bit instance for the
//               main graphs and an 8-bit instance for saturation. Expected
//               values are hand-computed shortest paths. Honours the
//               BF_NEG_CYCLE_DETECT_EN macro when predicting neg_cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf_relax_engine;
  localparam int VW  = 8;
  localparam int EAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rd_cnt = 0;
  int   last_cyc;

  int m_src [64];
  int m_dst [64];
  int m_wt  [64];

  bf_relax_engine_if #(.VERT_W(VW), .DIST_W(16), .EDGE_AW(EAW)) bus  ();
  bf_relax_engine_if #(.VERT_W(VW), .DIST_W(8),  .EDGE_AW(EAW)) bus8 ();

  bf_relax_engine #(.VERT_W(VW), .DIST_W(16), .EDGE_AW(EAW)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave));
  bf_relax_engine #(.VERT_W(VW), .DIST_W(8), .EDGE_AW(EAW)) u_dut8 (
    .clk (clk), .rst (rst), .bus (bus8.slave));

  always #5 clk = ~clk;

  // Edge RAM models: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.o_edge_rd) begin
      bus.i_edge_src <= VW'(m_src[bus.o_edge_addr[5:0]]);
      bus.i_edge_dst <= VW'(m_dst[bus.o_edge_addr[5:0]]);
      bus.i_edge_wt  <= 16'(m_wt[bus.o_edge_addr[5:0]]);
    end
    if (bus8.o_edge_rd) begin
      bus8.i_edge_src <= VW'(m_src[bus8.o_edge_addr[5:0]]);
      bus8.i_edge_dst <= VW'(m_dst[bus8.o_edge_addr[5:0]]);
      bus8.i_edge_wt  <= 8'(m_wt[bus8.o_edge_addr[5:0]]);
    end
  end

  always @(posedge clk) if (bus.o_edge_rd) rd_cnt <= rd_cnt + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_edge(input int i, input int s, input int d, input int w);
    m_src[i] = s; m_dst[i] = d; m_wt[i] = w;
  endtask

  // Pulse start on one instance and wait (bounded) for done; checks pulse width.
  task automatic run(input bit w8, input int v, input int e, input int s, input string tag);
    int cyc;
    @(negedge clk);
    if (w8) begin
      bus8.i_start = 1'b1; bus8.i_vertex_num = (VW+1)'(v);
      bus8.i_edge_num = (EAW+1)'(e); bus8.i_source_num = VW'(s);
    end else begin
      bus.i_start = 1'b1; bus.i_vertex_num = (VW+1)'(v);
      bus.i_edge_num = (EAW+1)'(e); bus.i_source_num = VW'(s);
    end
    @(negedge clk);
    bus.i_start = 1'b0; bus8.i_start = 1'b0;
    cyc = 1;
    while (!(w8 ? bus8.o_done : bus.o_done) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    last_cyc = cyc;
    chk({tag, " done"}, 64'(w8 ? bus8.o_done : bus.o_done), 1);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(w8 ? bus8.o_done : bus.o_done), 0);
  endtask

  task automatic q(input bit w8, input int a, output logic signed [63:0] d, output logic signed [63:0] p);
    @(negedge clk);
    bus.i_q_addr = VW'(a); bus8.i_q_addr = VW'(a);
    @(negedge clk);
    d = w8 ? 64'($signed(bus8.o_q_dist)) : 64'($signed(bus.o_q_dist));
    p = w8 ? 64'(bus8.o_q_pred) : 64'(bus.o_q_pred);
  endtask

  task automatic load_t1();
    set_edge(0, 0, 1, 4); set_edge(1, 0, 2, 1); set_edge(2, 2, 1, 2); set_edge(3, 1, 3, 1);
  endtask

  task automatic check_t1(input string tag);
    int exp_d [4] = '{0, 3, 1, 4};
    int exp_p [4] = '{0, 2, 0, 1};
    logic signed [63:0] d, p;
    for (int i = 0; i < 4; i++) begin
      q(1'b0, i, d, p);
      chk($sformatf("%s dist%0d", tag, i), d, exp_d[i]);
      chk($sformatf("%s pred%0d", tag, i), p, exp_p[i]);
    end
  endtask

  initial begin
    logic signed [63:0] d, p;
    int rd0;
    int exp_neg;
    bus.i_start = 0; bus.i_vertex_num = '0; bus.i_edge_num = '0; bus.i_source_num = '0; bus.i_q_addr = '0;
    bus8.i_start = 0; bus8.i_vertex_num = '0; bus8.i_edge_num = '0; bus8.i_source_num = '0; bus8.i_q_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(bus.o_busy), 0);
    chk("rst done", 64'(bus.o_done), 0);
    chk("rst err", 64'(bus.o_err), 0);
    chk("rst neg", 64'(bus.o_neg_cycle), 0);
    chk("rst edge_rd", 64'(bus.o_edge_rd), 0);
    chk("rst edge_addr", 64'(bus.o_edge_addr), 0);
    chk("rst passes", 64'(bus.o_passes), 0);
    chk("rst q_dist", 64'(bus.o_q_dist), 0);
    chk("rst q_pred", 64'(bus.o_q_pred), 0);
    rst = 1'b0;

    // Test 1: small diamond graph
    load_t1();
    run(1'b0, 4, 4, 0, "t1");
    chk("t1 passes", 64'(bus.o_passes), 2);
    chk("t1 err", 64'(bus.o_err), 0);
    chk("t1 busy_after", 64'(bus.o_busy), 0);
    check_t1("t1");

    // Test 2: chain in reverse then forward order
    set_edge(0, 3, 4, 1); set_edge(1, 2, 3, 1); set_edge(2, 1, 2, 1); set_edge(3, 0, 1, 1);
    run(1'b0, 5, 4, 0, "t2r");
    chk("t2r passes", 64'(bus.o_passes), 4);
    chk("t2r neg", 64'(bus.o_neg_cycle), 0);
    q(1'b0, 4, d, p);
    chk("t2r dist4", d, 4);
    chk("t2r pred4", p, 3);
    set_edge(0, 0, 1, 1); set_edge(1, 1, 2, 1); set_edge(2, 2, 3, 1); set_edge(3, 3, 4, 1);
    run(1'b0, 5, 4, 0, "t2f");
    chk("t2f passes", 64'(bus.o_passes), 2);
    q(1'b0, 4, d, p);
    chk("t2f dist4", d, 4);

    // Test 3: bad source, then clearing start
    rd0 = rd_cnt;
    run(1'b0, 3, 4, 5, "t3");
    chk("t3 latency", last_cyc, 1);
    chk("t3 err", 64'(bus.o_err), 1);
    chk("t3 no_rd", rd_cnt - rd0, 0);
    load_t1();
    run(1'b0, 4, 4, 0, "t3b");
    chk("t3b err_clr", 64'(bus.o_err), 0);

    // V==0, E==0 and out-of-range edge boundaries
    run(1'b0, 0, 4, 0, "v0");
    chk("v0 latency", last_cyc, 1);
    chk("v0 passes", 64'(bus.o_passes), 0);
    chk("v0 err", 64'(bus.o_err), 0);
    run(1'b0, 3, 0, 0, "e0");
    chk("e0 passes", 64'(bus.o_passes), 0);
    q(1'b0, 1, d, p);
    chk("e0 dist1", d, 32767);
    chk("e0 pred1", p, 1);
    set_edge(0, 0, 7, 1); set_edge(1, 0, 1, 5);
    run(1'b0, 3, 2, 0, "oor");
    chk("oor passes", 64'(bus.o_passes), 2);
    q(1'b0, 1, d, p);
    chk("oor dist1", d, 5);
    q(1'b0, 2, d, p);
    chk("oor dist2", d, 32767);

    // Test 4: negative cycle 1<->2
    set_edge(0, 0, 1, 1); set_edge(1, 1, 2, -3); set_edge(2, 2, 1, 1);
    run(1'b0, 3, 3, 0, "t4");
`ifdef BF_NEG_CYCLE_DETECT_EN
    exp_neg = 1;
`else
    exp_neg = 0;
`endif
    chk("t4 neg", 64'(bus.o_neg_cycle), exp_neg);
    chk("t4 passes", 64'(bus.o_passes), 2);
    q(1'b0, 2, d, p);
    chk("t4 dist2", d, -4);
    q(1'b0, 1, d, p);
    chk("t4 dist1", d, -3);

    // Test 5: saturation on the 8-bit instance
    set_edge(0, 0, 1, 100); set_edge(1, 1, 2, 100);
    run(1'b1, 4, 2, 0, "t5");
    chk("t5 passes", 64'(bus8.o_passes), 2);
    q(1'b1, 1, d, p);
    chk("t5 dist1", d, 100);
    q(1'b1, 2, d, p);
    chk("t5 dist2_sat", d, 126);
    chk("t5 pred2", p, 1);
    q(1'b1, 3, d, p);
    chk("t5 dist3_inf", d, 127);

    // Test 6: reset during RELAX, then rerun
    load_t1();
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_vertex_num = 9'd4; bus.i_edge_num = 11'd4; bus.i_source_num = 8'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    begin
      int n = 0;
      while (!bus.o_edge_rd && n < 100) begin @(negedge clk); n++; end
      chk("t6 saw_fetch", 64'(bus.o_edge_rd), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 busy_async", 64'(bus.o_busy), 0);
    @(posedge clk); #1;
    chk("t6 busy", 64'(bus.o_busy), 0);
    chk("t6 done", 64'(bus.o_done), 0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 4, 4, 0, "t6r");
    chk("t6r passes", 64'(bus.o_passes), 2);
    check_t1("t6r");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule : tb_bf_relax_engine
`default_nettype wire
